// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: ROM address/data pair and the decode-side
// valid/ready handshake carrying the head instruction and its address.
interface instr_fetch_if #(
  parameter int AW = 8,
  parameter int IW = 6
);
  logic [AW-1:0] mem_addr;
  logic [IW-1:0] mem_instr;
  logic          out_valid;
  logic [IW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic          out_ready;

  // Fetch unit: drives ROM address and the decode-facing outputs
  modport master (
    output mem_addr,
    input  mem_instr,
    output out_valid,
    output out_instr,
    output out_pc,
    input  out_ready
  );

  // ROM plus decode: return instruction data and accept head entries
  modport slave (
    input  mem_addr,
    output mem_instr,
    input  out_valid,
    input  out_instr,
    input  out_pc,
    output out_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch / prefetch stage. Drives the combinational ROM from the
// fetch PC register, captures {pc, instr} into a small FIFO and hands the
// head entry to decode over valid/ready. A redirect flushes the FIFO and
// restarts fetching at the new target on the following cycle.
module instr_fetch #(
  parameter int AW       = 8,
  parameter int IW       = 6,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  instr_fetch_if.master              fif,
  input  logic                       fetch_en,
  input  logic                       redirect,
  input  logic [AW-1:0]              redirect_pc,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
  localparam logic [AW-1:0] PC_ONE    = AW'(1);

  logic [AW-1:0] fetch_pc_r;
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [AW-1:0] pc_mem_r    [DEPTH];
  logic [IW-1:0] instr_mem_r [DEPTH];

  logic          out_valid_s;
  logic          pop_s;
  logic          push_s;
  logic [IW-1:0] out_instr_s;
  logic [AW-1:0] out_pc_s;

  assign out_valid_s = (count_r != {CW{1'b0}});
  assign pop_s       = out_valid_s & fif.out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle,
  // which keeps streaming at one instruction per cycle.
  assign push_s      = fetch_en & ~redirect & ((count_r < CNT_DEPTH) | pop_s);

  // Fetch PC, FIFO pointers and occupancy; redirect overrides everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_r <= AW'(RESET_PC);
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
    end else if (redirect) begin
      // Any coinciding pop is treated as accepted; its entry is dropped with the rest
      fetch_pc_r <= redirect_pc;
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        fetch_pc_r <= fetch_pc_r + PC_ONE;
        wr_ptr_r   <= wr_ptr_r + PTR_ONE;
      end else begin
        fetch_pc_r <= fetch_pc_r;
        wr_ptr_r   <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are only meaningful under count, so no reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem_r[wr_ptr_r]    <= fetch_pc_r;
      instr_mem_r[wr_ptr_r] <= fif.mem_instr;
    end
  end

  // Head entry presented to decode, zeroed while the FIFO is empty
  always_comb begin
    out_instr_s = {IW{1'b0}};
    out_pc_s    = {AW{1'b0}};
    if (out_valid_s) begin
      out_instr_s = instr_mem_r[rd_ptr_r];
      out_pc_s    = pc_mem_r[rd_ptr_r];
    end else begin
      out_instr_s = {IW{1'b0}};
      out_pc_s    = {AW{1'b0}};
    end
  end

  assign fif.mem_addr  = fetch_pc_r;
  assign fif.out_valid = out_valid_s;
  assign fif.out_instr = out_instr_s;
  assign fif.out_pc    = out_pc_s;
  assign fifo_count    = count_r;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch and prefetch stage sitting between the program counter domain and the decode stage of the CPU. It drives the address of the combinational instruction ROM, captures each returned instruction word with its address into a small prefetch FIFO, and presents it to decode over a valid/ready handshake. Branch redirects flush the FIFO and restart fetching at the new target.

## Interface

- AW, 8, address width; fetch PC wraps modulo 2^AW
- IW, 6, instruction word width
- DEPTH, 4, prefetch FIFO entries; power of two, at least 2
- RESET_PC, 0, fetch PC after reset
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_addr  out  AW  ROM address, equal to fetch_pc register
- mem_instr  in  IW  ROM data, combinational from mem_addr, same cycle
- fetch_en  in  1  1 = fetch allowed; 0 = hold fetch_pc, no push
- redirect  in  1  flush and restart at redirect_pc
- redirect_pc  in  AW  new fetch target
- out_valid  out  1  head entry valid
- out_instr  out  IW  head instruction; 0 when out_valid=0
- out_pc  out  AW  address of head instruction; 0 when out_valid=0
- out_ready  in  1  decode accepts head this cycle
- fifo_count  out  log2(DEPTH)+1  occupied entries, debug

## Operation

- State: fetch_pc, FIFO storage of {pc, instr} per entry, wr_ptr, rd_ptr, count.
- pop = out_valid & out_ready.
- push = fetch_en & ~redirect & (count < DEPTH | pop). Push writes {fetch_pc, mem_instr} at wr_ptr; fetch_pc <= fetch_pc + 1 mod 2^AW.
- Full FIFO with simultaneous pop: push permitted, count unchanged, sustained throughput one instruction per cycle.
- Empty FIFO: no bypass; a pushed entry becomes visible the following cycle.
- Redirect (highest priority): count <= 0, rd_ptr <= wr_ptr <= 0, fetch_pc <= redirect_pc, no push. A pop coinciding with redirect counts as accepted by the consumer; the entry is discarded with the rest.
- fetch_en=0: fetch_pc and mem_addr held; pops continue draining.
- Pointers wrap modulo DEPTH; count never exceeds DEPTH and never underflows (pop is qualified by out_valid).
- out_valid = (count != 0); outputs driven from head entry, forced to 0 when empty.
- No pipeline states beyond FIFO occupancy; behaviour fully defined by count, pointers, fetch_pc.

## Timing

- Reset (rst_n low, asynchronous): fetch_pc=RESET_PC, mem_addr=RESET_PC, count=0, out_valid=0, out_instr=0, out_pc=0, fifo_count=0. Storage contents need not be cleared.
- First cycle after rst_n release with fetch_en=1: push of RESET_PC; out_valid=1, out_pc=RESET_PC on next cycle.
- Fetch-to-output latency: 1 cycle when FIFO empty.
- Redirect at cycle N: cycle N+1 out_valid=0, mem_addr=redirect_pc; cycle N+2 out_valid=1, out_pc=redirect_pc (fetch_en=1).
- Back-to-back redirects: each later redirect wins; only the last target is fetched.
- Reset asserted mid-operation: immediate return to reset values regardless of FIFO state or pending redirect.
- out_valid never drops without a pop, redirect, or reset; head entry stable while out_valid=1 and out_ready=0.

## Test plan

- Stream: reset, fetch_en=1, out_ready=1 -> out_pc 0x00,0x01,0x02,... on consecutive cycles starting cycle 1 after release, out_instr equal to ROM model at each address.
- Backpressure: out_ready=0 for 10 cycles -> fifo_count reaches 4, mem_addr holds 0x04, out_pc holds 0x00; release -> 0x00..0x03 then 0x04 in order, none lost or duplicated.
- Redirect while full: FIFO full, redirect=1 redirect_pc=0x0A -> next cycle out_valid=0, fifo_count=0, mem_addr=0x0A; following cycle out_pc=0x0A.
- Wrap: redirect to 0xFE, out_ready=1 -> out_pc 0xFE, 0xFF, 0x00, 0x01.
- Full with concurrent pop: fill to 4, then out_ready=1 continuously -> fifo_count stays 4, one new out_pc per cycle, consecutive addresses.
- Reset mid-run: assert rst_n=0 asynchronously with fifo_count=3 -> out_valid=0, out_pc=0, mem_addr=RESET_PC immediately, before next clock edge.
